// File: rtl/imem_line_buffer_pkg.sv
// Shared LC-3b fetch-path types and the line buffer FSM state encoding.
// Optional feature macro: IMEM_NEXT_LINE_PREFETCH_EN adds the PREFETCH state
// and a second (prefetch) line entry.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;
  typedef logic [11:0]  lc3b_line_tag;

`ifdef IMEM_NEXT_LINE_PREFETCH_EN
  localparam int IMEM_NUM_ENTRIES = 2;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    PREFETCH = 2'd2
  } imem_state_t;
`else
  localparam int IMEM_NUM_ENTRIES = 1;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1
  } imem_state_t;
`endif

  // Line-aligned byte address for a tag (offset bits forced to zero).
  function automatic lc3b_word line_base(input lc3b_line_tag tag);
    return {tag, 4'h0};
  endfunction

endpackage

// File: rtl/imem_line_entry.sv
// One buffered instruction line: valid bit, 12-bit line tag, 128-bit data,
// plus the tag-match compare against the current lookup tag.
module imem_line_entry
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         clear,
  input  lc3b_line_tag tag_in,
  input  lc3b_data     line_in,
  input  lc3b_line_tag lookup_tag,
  output logic         valid,
  output lc3b_line_tag tag,
  output lc3b_data     line,
  output logic         match
);

  logic         valid_reg;
  lc3b_line_tag tag_reg;
  lc3b_data     line_reg;

  // Entry storage: a load always wins over a clear issued on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      line_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      tag_reg   <= tag_in;
      line_reg  <= line_in;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign tag   = tag_reg;
  assign line  = line_reg;
  assign match = valid_reg && (tag_reg == lookup_tag);

endmodule

// File: rtl/imem_line_buffer.sv
// Instruction-fetch line buffer: zero-latency hit on a held 128-bit line,
// otherwise a single-line read on the pmem bus with a give-up-and-retry
// watchdog. Optional feature macro: IMEM_NEXT_LINE_PREFETCH_EN (next-line
// prefetch into a second entry, promoted to the demand entry on a hit).
module imem_line_buffer
  import lc3b_types::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic     clk,
  input  logic     reset_n,
  input  lc3b_word imem_address,
  input  logic     imem_action_stb,
  input  logic     imem_action_cyc,
  output lc3b_data imem_rdata,
  output logic     imem_resp,
  output lc3b_word pmem_address,
  output logic     pmem_cyc,
  output logic     pmem_stb,
  input  logic     pmem_ack,
  input  lc3b_data pmem_rdata
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  // Entry 0 is the demand entry; entry 1 (when present) holds the prefetch.
  logic [IMEM_NUM_ENTRIES-1:0] ent_load;
  logic [IMEM_NUM_ENTRIES-1:0] ent_clear;
  logic [IMEM_NUM_ENTRIES-1:0] ent_valid;
  logic [IMEM_NUM_ENTRIES-1:0] ent_match;
  lc3b_line_tag                ent_tag_in [IMEM_NUM_ENTRIES];
  lc3b_data                    ent_line_in[IMEM_NUM_ENTRIES];
  lc3b_line_tag                ent_tag    [IMEM_NUM_ENTRIES];
  lc3b_data                    ent_line   [IMEM_NUM_ENTRIES];

  imem_state_t       state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  lc3b_word          pmem_address_reg, pmem_address_next;

  logic         req;
  lc3b_line_tag req_tag;
  logic         demand_hit;
  logic         pf_hit;
  logic         miss;
  logic         timeout;

`ifdef IMEM_NEXT_LINE_PREFETCH_EN
  logic         pf_pending_reg, pf_pending_next;
  lc3b_line_tag pf_tag_reg, pf_tag_next;
  logic         pf_held;
`endif

  for (genvar gi = 0; gi < IMEM_NUM_ENTRIES; gi++) begin : g_entry
    imem_line_entry u_entry (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (ent_load[gi]),
      .clear      (ent_clear[gi]),
      .tag_in     (ent_tag_in[gi]),
      .line_in    (ent_line_in[gi]),
      .lookup_tag (req_tag),
      .valid      (ent_valid[gi]),
      .tag        (ent_tag[gi]),
      .line       (ent_line[gi]),
      .match      (ent_match[gi])
    );
  end

  assign req        = imem_action_stb && imem_action_cyc;
  assign req_tag    = imem_address[15:4];
  assign demand_hit = req && ent_match[0];
`ifdef IMEM_NEXT_LINE_PREFETCH_EN
  assign pf_hit  = req && ent_match[1] && !ent_match[0];
  assign pf_held = (ent_valid[0] && (ent_tag[0] == pf_tag_reg)) ||
                   (ent_valid[1] && (ent_tag[1] == pf_tag_reg));
`else
  assign pf_hit = 1'b0;
`endif
  assign miss    = req && !demand_hit && !pf_hit;
  assign timeout = (wait_reg == WAIT_LAST);

  // Hit path is purely combinational so a held line answers in the request cycle.
  always_comb begin
    imem_resp  = demand_hit || pf_hit;
    imem_rdata = '0;
    if (demand_hit) begin
      imem_rdata = ent_line[0];
`ifdef IMEM_NEXT_LINE_PREFETCH_EN
    end else if (pf_hit) begin
      imem_rdata = ent_line[1];
`endif
    end
  end

  assign pmem_cyc     = (state_reg != IDLE);
  assign pmem_stb     = pmem_cyc;
  assign pmem_address = pmem_address_reg;

  // Next-state, bus address, watchdog and entry write controls.
  always_comb begin
    state_next        = state_reg;
    wait_next         = wait_reg;
    pmem_address_next = pmem_address_reg;
    ent_load          = '0;
    ent_clear         = '0;
    for (int i = 0; i < IMEM_NUM_ENTRIES; i++) begin
      ent_tag_in[i]  = pmem_address_reg[15:4];
      ent_line_in[i] = pmem_rdata;
    end
`ifdef IMEM_NEXT_LINE_PREFETCH_EN
    pf_pending_next = pf_pending_reg;
    pf_tag_next     = pf_tag_reg;
`endif

    case (state_reg)
      IDLE: begin
        // A stray ack here belongs to an abandoned cycle and is dropped.
        wait_next = '0;
        if (miss) begin
          state_next        = FETCH;
          pmem_address_next = line_base(req_tag);
`ifdef IMEM_NEXT_LINE_PREFETCH_EN
        end else if (pf_pending_reg) begin
          pf_pending_next = 1'b0;
          if (!pf_held) begin
            state_next        = PREFETCH;
            pmem_address_next = line_base(pf_tag_reg);
          end
`endif
        end
      end

      FETCH: begin
        if (pmem_ack) begin
          ent_load[0] = 1'b1;
          state_next  = IDLE;
          wait_next   = '0;
`ifdef IMEM_NEXT_LINE_PREFETCH_EN
          pf_pending_next = 1'b1;
          pf_tag_next     = pmem_address_reg[15:4] + 12'd1;
`endif
        end else if (timeout) begin
          state_next = IDLE;
          wait_next  = '0;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end

`ifdef IMEM_NEXT_LINE_PREFETCH_EN
      PREFETCH: begin
        if (pmem_ack) begin
          ent_load[1] = 1'b1;
          state_next  = IDLE;
          wait_next   = '0;
        end else if (timeout) begin
          state_next = IDLE;
          wait_next  = '0;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
`endif

      default: begin
        state_next = IDLE;
        wait_next  = '0;
      end
    endcase

`ifdef IMEM_NEXT_LINE_PREFETCH_EN
    // Move a hit prefetch line into the demand slot unless a fill owns it this edge.
    if (pf_hit && !ent_load[0]) begin
      ent_load[0]    = 1'b1;
      ent_tag_in[0]  = ent_tag[1];
      ent_line_in[0] = ent_line[1];
      ent_clear[1]   = 1'b1;
    end
`endif
  end

  // State, watchdog and latched bus address registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      wait_reg         <= '0;
      pmem_address_reg <= '0;
    end else begin
      state_reg        <= state_next;
      wait_reg         <= wait_next;
      pmem_address_reg <= pmem_address_next;
    end
  end

`ifdef IMEM_NEXT_LINE_PREFETCH_EN
  // Pending next-line prefetch target, armed by each demand fill.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pf_pending_reg <= 1'b0;
      pf_tag_reg     <= '0;
    end else begin
      pf_pending_reg <= pf_pending_next;
      pf_tag_reg     <= pf_tag_next;
    end
  end
`endif

endmodule

// File: tb/tb_imem_line_buffer.sv
// Directed self-checking bench for imem_line_buffer (MAX_WAIT = 4).
// The next-line prefetch scenario runs only when IMEM_NEXT_LINE_PREFETCH_EN is defined.
module tb_imem_line_buffer;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     reset_n;
  lc3b_word imem_address;
  logic     imem_action_stb;
  logic     imem_action_cyc;
  lc3b_data imem_rdata;
  logic     imem_resp;
  lc3b_word pmem_address;
  logic     pmem_cyc;
  logic     pmem_stb;
  logic     pmem_ack;
  lc3b_data pmem_rdata;

  int errors = 0;
  int checks = 0;

  localparam lc3b_data D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam lc3b_data D1 = 128'h11111111_22222222_33333333_44444444;
  localparam lc3b_data D2 = 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_CAFEF00D;
  localparam lc3b_data D3 = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
  localparam lc3b_data D4 = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;

  imem_line_buffer #(.MAX_WAIT(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_address    (imem_address),
    .imem_action_stb (imem_action_stb),
    .imem_action_cyc (imem_action_cyc),
    .imem_rdata      (imem_rdata),
    .imem_resp       (imem_resp),
    .pmem_address    (pmem_address),
    .pmem_cyc        (pmem_cyc),
    .pmem_stb        (pmem_stb),
    .pmem_ack        (pmem_ack),
    .pmem_rdata      (pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input lc3b_word addr, input logic on);
    imem_address    = addr;
    imem_action_stb = on;
    imem_action_cyc = on;
  endtask

  // Bounded wait for the bus request to rise; n is cycles waited.
  task automatic wait_bus(output logic got, output int n);
    got = 1'b0;
    n   = 0;
    while (!got && n < 12) begin
      step(); #1;
      n++;
      if (pmem_cyc) got = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_req(16'h0000, 1'b0);
    pmem_ack   = 1'b0;
    pmem_rdata = '0;
    step(); step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b exp=0", imem_resp); end
    checks++; if (imem_rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", imem_rdata); end
    checks++; if (pmem_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc got=%b exp=0", pmem_cyc); end
    checks++; if (pmem_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got=%b exp=0", pmem_stb); end
    checks++; if (pmem_address !== 16'h0000) begin errors++; $display("FAIL reset_addr got=%h exp=0000", pmem_address); end
    $display("reset: outputs checked");
  endtask

  task automatic test_fetch();
    logic got;
    int   n;
    step();
    set_req(16'h3006, 1'b1); #1;
    checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL fetch_miss_resp got=%b exp=0", imem_resp); end
    wait_bus(got, n);
    checks++; if (n !== 1 || got !== 1'b1) begin errors++; $display("FAIL fetch_start got=%0d/%b exp=1/1", n, got); end
    checks++; if (pmem_address !== 16'h3000) begin errors++; $display("FAIL fetch_addr got=%h exp=3000", pmem_address); end
    checks++; if (pmem_stb !== 1'b1) begin errors++; $display("FAIL fetch_stb got=%b exp=1", pmem_stb); end
    step(); #1;
    checks++; if (pmem_address !== 16'h3000 || pmem_cyc !== 1'b1) begin errors++; $display("FAIL fetch_hold got=%h/%b exp=3000/1", pmem_address, pmem_cyc); end
    step();
    pmem_ack = 1'b1; pmem_rdata = D0;
    step();
    pmem_ack = 1'b0; pmem_rdata = '0; #1;
    checks++; if (imem_resp !== 1'b1) begin errors++; $display("FAIL fetch_resp got=%b exp=1", imem_resp); end
    checks++; if (imem_rdata !== D0) begin errors++; $display("FAIL fetch_rdata got=%h exp=%h", imem_rdata, D0); end
    checks++; if (pmem_cyc !== 1'b0) begin errors++; $display("FAIL fetch_done_cyc got=%b exp=0", pmem_cyc); end
    $display("fetch: 3006 filled from 3000");
  endtask

  task automatic test_hit();
    int busy = 0;
    step();
    set_req(16'h300E, 1'b1); #1;
    checks++; if (imem_resp !== 1'b1) begin errors++; $display("FAIL hit_resp got=%b exp=1", imem_resp); end
    checks++; if (imem_rdata !== D0) begin errors++; $display("FAIL hit_rdata got=%h exp=%h", imem_rdata, D0); end
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      if (pmem_cyc) busy++;
    end
    checks++; if (busy !== 0) begin errors++; $display("FAIL hit_no_bus got=%0d exp=0", busy); end
    imem_action_stb = 1'b0; #1;
    checks++; if (imem_resp !== 1'b0) begin errors++; $display("FAIL hit_no_req_resp got=%b exp=0", imem_resp); end
    set_req(16'h300E, 1'b0);
    $display("hit: 300E served with zero latency");
  endtask

  task automatic test_redirect();
    logic got;
    int   n;
    do_reset();
    set_req(16'h3000, 1'b1);
    wait_bus(got, n);
    checks++; if (got !== 1'b1 || pmem_address !== 16'h3000) begin errors++; $display("FAIL redir_start got=%b/%h exp=1/3000", got, pmem_address); end
    step();
    set_req(16'h5000, 1'b1); #1;
    checks++; if (pmem_address !== 16'h3000 || pmem_cyc !== 1'b1) begin errors++; $display("FAIL redir_hold got=%h/%b exp=3000/1", pmem_address, pmem_cyc); end
    step();
    pmem_ack = 1'b1; pmem_rdata = D1;
    step();
    pmem_ack = 1'b0; pmem_rdata = '0; #1;
    checks++; if (imem_resp !== 1'b0 || pmem_cyc !== 1'b0) begin errors++; $display("FAIL redir_idle got=%b/%b exp=0/0", imem_resp, pmem_cyc); end
    step(); #1;
    checks++; if (pmem_cyc !== 1'b1 || pmem_address !== 16'h5000) begin errors++; $display("FAIL redir_refetch got=%b/%h exp=1/5000", pmem_cyc, pmem_address); end
    pmem_ack = 1'b1; pmem_rdata = D2;
    step();
    pmem_ack = 1'b0; pmem_rdata = '0; #1;
    checks++; if (imem_resp !== 1'b1 || imem_rdata !== D2) begin errors++; $display("FAIL redir_resp got=%b/%h exp=1/%h", imem_resp, imem_rdata, D2); end
    set_req(16'h5000, 1'b0);
    $display("redirect: 3000 fill completed, 5000 fetched");
  endtask

  task automatic test_timeout();
    logic       got;
    int         n;
    logic [6:0] pat = '0;
    do_reset();
    set_req(16'h7004, 1'b1);
    wait_bus(got, n);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL tmo_start got=%b exp=1", got); end
    pat = {pat[5:0], pmem_cyc};
    for (int i = 0; i < 6; i++) begin
      step(); #1;
      pat = {pat[5:0], pmem_cyc};
    end
    checks++; if (pat !== 7'b1111011) begin errors++; $display("FAIL tmo_pattern got=%b exp=1111011", pat); end
    checks++; if (pmem_address !== 16'h7000) begin errors++; $display("FAIL tmo_retry_addr got=%h exp=7000", pmem_address); end
    pmem_ack = 1'b1; pmem_rdata = D3;
    step();
    pmem_ack = 1'b0; pmem_rdata = '0; #1;
    checks++; if (imem_resp !== 1'b1 || imem_rdata !== D3) begin errors++; $display("FAIL tmo_resp got=%b/%h exp=1/%h", imem_resp, imem_rdata, D3); end
    set_req(16'h7004, 1'b0);
    $display("timeout: dropped once, retried 7000");
  endtask

  task automatic test_reset_mid_fetch();
    logic got;
    int   n;
    do_reset();
    set_req(16'h9008, 1'b1);
    wait_bus(got, n);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL mrst_start got=%b exp=1", got); end
    step();
    reset_n = 1'b0;
    set_req(16'h9008, 1'b0);
    step();
    reset_n = 1'b1;
    pmem_ack = 1'b1; pmem_rdata = D4; #1;
    checks++; if (pmem_cyc !== 1'b0 || pmem_stb !== 1'b0) begin errors++; $display("FAIL mrst_bus got=%b/%b exp=0/0", pmem_cyc, pmem_stb); end
    checks++; if (pmem_address !== 16'h0000) begin errors++; $display("FAIL mrst_addr got=%h exp=0000", pmem_address); end
    checks++; if (imem_resp !== 1'b0 || imem_rdata !== '0) begin errors++; $display("FAIL mrst_imem got=%b/%h exp=0/0", imem_resp, imem_rdata); end
    step();
    pmem_ack = 1'b0; pmem_rdata = '0;
    set_req(16'h9008, 1'b1); #1;
    checks++; if (imem_resp !== 1'b0 || imem_rdata !== '0) begin errors++; $display("FAIL mrst_stale got=%b/%h exp=0/0", imem_resp, imem_rdata); end
    step(); #1;
    checks++; if (pmem_cyc !== 1'b1 || pmem_address !== 16'h9000) begin errors++; $display("FAIL mrst_refetch got=%b/%h exp=1/9000", pmem_cyc, pmem_address); end
    pmem_ack = 1'b1; pmem_rdata = D1;
    step();
    pmem_ack = 1'b0; pmem_rdata = '0;
    set_req(16'h9008, 1'b0);
    $display("reset_mid_fetch: stale ack ignored");
  endtask

`ifdef IMEM_NEXT_LINE_PREFETCH_EN
  task automatic test_prefetch();
    logic got;
    int   n;
    do_reset();
    set_req(16'hFFF0, 1'b1);
    wait_bus(got, n);
    checks++; if (got !== 1'b1 || pmem_address !== 16'hFFF0) begin errors++; $display("FAIL pf_fetch got=%b/%h exp=1/fff0", got, pmem_address); end
    pmem_ack = 1'b1; pmem_rdata = D2;
    step();
    pmem_ack = 1'b0; pmem_rdata = '0; #1;
    checks++; if (imem_resp !== 1'b1 || imem_rdata !== D2) begin errors++; $display("FAIL pf_demand got=%b/%h exp=1/%h", imem_resp, imem_rdata, D2); end
    step(); #1;
    checks++; if (pmem_cyc !== 1'b1 || pmem_address !== 16'h0000) begin errors++; $display("FAIL pf_issue got=%b/%h exp=1/0000", pmem_cyc, pmem_address); end
    pmem_ack = 1'b1; pmem_rdata = D3;
    step();
    pmem_ack = 1'b0; pmem_rdata = '0;
    set_req(16'h0002, 1'b1); #1;
    checks++; if (imem_resp !== 1'b1 || imem_rdata !== D3) begin errors++; $display("FAIL pf_hit got=%b/%h exp=1/%h", imem_resp, imem_rdata, D3); end
    set_req(16'h0002, 1'b0);
    $display("prefetch: fff0 fill prefetched 0000");
  endtask
`endif

  initial begin
    reset_n         = 1'b0;
    imem_address    = '0;
    imem_action_stb = 1'b0;
    imem_action_cyc = 1'b0;
    pmem_ack        = 1'b0;
    pmem_rdata      = '0;
    test_reset();
    test_fetch();
    test_hit();
    test_redirect();
    test_timeout();
    test_reset_mid_fetch();
`ifdef IMEM_NEXT_LINE_PREFETCH_EN
    test_prefetch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
